// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg: shared types for the rv32i unified-memory arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : which requester owns the in-flight transaction
//   mem_req_t   : registered memory request (we, addr, wdata, wstrb)
// The struct fields are sized by MEM_ADDR_W / MEM_DATA_W. Top-level widths are
// cast into and out of these fields, so these values set the widest supported
// ADDR_W and DATA_W.
package rv32i_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_STRB_W = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_STRB_W-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/rv32i_arb_prio.sv
// rv32i_arb_prio: winner select between IF and D, plus the starvation counter.
//   clk, reset : clock and synchronous active-high reset
//   arb_en     : an arbitration is taken this cycle (IDLE with a request pending)
//   if_req     : IF request pending
//   d_req      : D request pending
//   d_win      : 1 = D wins, 0 = IF wins (meaningful only while arb_en is high)
module rv32i_arb_prio
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic d_win
);

  localparam int unsigned CNT_W = $clog2(MAX_STARVE + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt >= CNT_W'(MAX_STARVE));
  // A lone D request always wins, even when the counter is saturated.
  assign d_win   = d_req && (!if_req || !starved);

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!d_win) begin
        starve_cnt <= '0;
      end else if (if_req && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one memory port between the IF fetch stage
// (read-only) and the D load/store stage.
//   IF side  : if_req/if_addr in; if_gnt, if_rvalid, if_rdata out
//   D side   : d_req/d_we/d_addr/d_wdata/d_wstrb in; d_gnt, d_rvalid, d_rdata out
//   memory   : mem_req/we/addr/wdata/wstrb out; mem_ack, mem_rvalid, mem_rdata in
//   busy     : transaction in progress
// Optional feature macro ARB_PERF_CNT_EN adds the 32-bit outputs perf_if_wait
// (cycles IF waits ungranted) and perf_conflict (arbitrations with both
// requests pending).
module rv32i_mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ack,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_if_wait,
  output logic [31:0]         perf_conflict
`endif
);

  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_e state_q, state_d;
  owner_e     owner_q;
  mem_req_t   req_q;
  logic       d_win;
  logic       arb_en;
  logic       load;
  logic       capture;

  rv32i_arb_prio #(
    .MAX_STARVE (MAX_STARVE)
  ) u_prio (
    .clk    (clk),
    .reset  (reset),
    .arb_en (arb_en),
    .if_req (if_req),
    .d_req  (d_req),
    .d_win  (d_win)
  );

  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    load    = 1'b0;
    capture = 1'b0;
    if_gnt  = 1'b0;
    d_gnt   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          arb_en  = 1'b1;
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          if (owner_q == OWN_IF) if_gnt = 1'b1;
          else                   d_gnt  = 1'b1;
          if (req_q.we) begin
            state_d = IDLE;
          end else if (mem_rvalid) begin
            // Response in the ack cycle: skip WAIT_RSP entirely.
            capture = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= OWN_IF;
      req_q     <= '0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if (load) begin
        if (d_win) begin
          owner_q <= OWN_D;
          req_q   <= '{we:    d_we,
                       addr:  MEM_ADDR_W'(d_addr),
                       wdata: MEM_DATA_W'(d_wdata),
                       wstrb: MEM_STRB_W'(d_wstrb)};
        end else begin
          owner_q <= OWN_IF;
          req_q   <= '{we:    1'b0,
                       addr:  MEM_ADDR_W'(if_addr),
                       wdata: '0,
                       wstrb: '0};
        end
      end
      if_rvalid <= capture && (owner_q == OWN_IF);
      d_rvalid  <= capture && (owner_q == OWN_D);
      if (capture && (owner_q == OWN_IF)) if_rdata <= mem_rdata;
      if (capture && (owner_q == OWN_D))  d_rdata  <= mem_rdata;
    end
  end

  assign mem_req   = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign mem_we    = req_q.we;
  assign mem_addr  = ADDR_W'(req_q.addr);
  assign mem_wdata = DATA_W'(req_q.wdata);
  assign mem_wstrb = STRB_W'(req_q.wstrb);

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_if_wait  <= '0;
      perf_conflict <= '0;
    end else begin
      perf_if_wait  <= perf_if_wait + 32'(if_req && !if_gnt);
      perf_conflict <= perf_conflict + 32'(arb_en && if_req && d_req);
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter: directed bench for rv32i_mem_arbiter with a
// transaction-phase reference model compared every cycle, a behavioural
// memory responder and literal expectations per scenario.
module tb_rv32i_mem_arbiter;

  localparam int MAX_STARVE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_req, mem_we, mem_ack, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait, perf_conflict;
`endif

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MAX_STARVE (MAX_STARVE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_wstrb    (d_wstrb),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_wait  (perf_if_wait),
    .perf_conflict (perf_conflict)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- requesters ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dreq_t;

  logic [31:0] if_q[$];
  dreq_t       d_q[$];
  bit          if_gnt_seen = 0;
  bit          d_gnt_seen  = 0;

  always @(posedge clk) begin
    #1;
    if (if_gnt_seen) begin
      if_gnt_seen = 0;
      if (if_q.size() > 0) void'(if_q.pop_front());
    end
    if (d_gnt_seen) begin
      d_gnt_seen = 0;
      if (d_q.size() > 0) void'(d_q.pop_front());
    end
    if (if_q.size() > 0) begin
      if_req  = 1'b1;
      if_addr = if_q[0];
    end else begin
      if_req  = 1'b0;
    end
    if (d_q.size() > 0) begin
      d_req   = 1'b1;
      d_we    = d_q[0].we;
      d_addr  = d_q[0].addr;
      d_wdata = d_q[0].wdata;
      d_wstrb = d_q[0].wstrb;
    end else begin
      d_req   = 1'b0;
    end
  end

  // ---------------- memory responder ----------------
  int          ack_lat  = 1;
  int          rsp_lat  = 1;
  bit          stray_en = 0;
  int          ack_cnt  = 0;
  int          rsp_cnt  = -1;
  logic [31:0] rsp_word;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    #1;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom();
    if (!mem_req) ack_cnt = 0;
    if (rsp_cnt > 0) rsp_cnt--;
    if (rsp_cnt == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rsp_word;
      rsp_cnt    = -1;
    end else if (mem_req) begin
      if (ack_cnt >= ack_lat) begin
        mem_ack = 1'b1;
        ack_cnt = 0;
        if (mem_we) begin
          w = mem_rd(mem_addr);
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          mem[mem_addr] = w;
        end else begin
          rsp_word = mem_rd(mem_addr);
          if (rsp_lat == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rsp_word;
          end else begin
            rsp_cnt = rsp_lat;
          end
        end
      end else begin
        ack_cnt++;
        if (stray_en) mem_rvalid = 1'b1;
      end
    end else if (stray_en && rsp_cnt < 0) begin
      mem_rvalid = 1'b1;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  bit          started = 0;
  bit          m_busy = 0, m_acked = 0, m_own_d = 0, m_we = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  int          m_starve = 0;
  bit          e_ifrv = 0, e_drv = 0;
  logic [31:0] e_ifrd = '0, e_drd = '0;
  logic [31:0] m_pw = '0, m_pc = '0;
  int          gnt_log[$];
  int          n_ifrv = 0, n_drv = 0, n_busy = 0;

  always @(negedge clk) begin
    bit exp_ifg, exp_dg, dwin;
    if (started) begin
      exp_ifg = m_busy && !m_acked && mem_ack && !m_own_d;
      exp_dg  = m_busy && !m_acked && mem_ack &&  m_own_d;
      check("busy", busy, 32'(m_busy));
      check("mem_req", mem_req, 32'(m_busy && !m_acked));
      if (m_busy && !m_acked) begin
        check("mem_we", mem_we, 32'(m_we));
        check("mem_addr", mem_addr, m_addr);
        if (m_we) begin
          check("mem_wdata", mem_wdata, m_wdata);
          check("mem_wstrb", mem_wstrb, 32'(m_wstrb));
        end
      end
      check("if_gnt", if_gnt, 32'(exp_ifg));
      check("d_gnt", d_gnt, 32'(exp_dg));
      check("if_rvalid", if_rvalid, 32'(e_ifrv));
      check("d_rvalid", d_rvalid, 32'(e_drv));
      check("if_rdata", if_rdata, e_ifrd);
      check("d_rdata", d_rdata, e_drd);
`ifdef ARB_PERF_CNT_EN
      check("perf_if_wait", perf_if_wait, m_pw);
      check("perf_conflict", perf_conflict, m_pc);
`endif
      if (if_gnt)    begin if_gnt_seen = 1; gnt_log.push_back(0); end
      if (d_gnt)     begin d_gnt_seen  = 1; gnt_log.push_back(1); end
      if (if_rvalid) n_ifrv++;
      if (d_rvalid)  n_drv++;
      if (busy)      n_busy++;

      if (reset) begin
        m_busy = 0; m_acked = 0; m_starve = 0;
        e_ifrv = 0; e_drv = 0; e_ifrd = '0; e_drd = '0;
        m_pw = '0; m_pc = '0;
      end else begin
        m_pw   = m_pw + 32'(if_req && !exp_ifg);
        e_ifrv = 0;
        e_drv  = 0;
        if (!m_busy) begin
          if (if_req || d_req) begin
            dwin = d_req && (!if_req || m_starve < MAX_STARVE);
            if (if_req && d_req) m_pc = m_pc + 1;
            if (dwin) begin
              if (if_req && m_starve < MAX_STARVE) m_starve++;
              m_own_d = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_wstrb = d_wstrb;
            end else begin
              m_starve = 0;
              m_own_d = 0; m_we = 0; m_addr = if_addr;
            end
            m_busy  = 1;
            m_acked = 0;
          end
        end else if (!m_acked) begin
          if (mem_ack) begin
            if (m_we) begin
              m_busy = 0;
            end else if (mem_rvalid) begin
              if (m_own_d) begin e_drv = 1; e_drd = mem_rdata; end
              else         begin e_ifrv = 1; e_ifrd = mem_rdata; end
              m_busy = 0;
            end else begin
              m_acked = 1;
            end
          end
        end else if (mem_rvalid) begin
          if (m_own_d) begin e_drv = 1; e_drd = mem_rdata; end
          else         begin e_ifrv = 1; e_ifrd = mem_rdata; end
          m_busy = 0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_stats();
    gnt_log.delete();
    n_ifrv = 0;
    n_drv  = 0;
    n_busy = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      if (if_q.size() == 0 && d_q.size() == 0 && !if_req && !d_req && !busy &&
          !m_busy && rsp_cnt < 0 && !e_ifrv && !e_drv) break;
      cyc++;
      if (cyc >= budget) begin
        total++;
        bad++;
        $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, cyc);
        break;
      end
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_wstrb"}, mem_wstrb, 0);
    check({tag, "_if_rvalid"}, if_rvalid, 0);
    check({tag, "_d_rvalid"}, d_rvalid, 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
`ifdef ARB_PERF_CNT_EN
    check({tag, "_perf_if_wait"}, perf_if_wait, 0);
    check({tag, "_perf_conflict"}, perf_conflict, 0);
`endif
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int cyc;
    reset = 1'b1;
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
    mem[32'h100]  = 32'h0050_0093;
    mem[32'h3000] = 32'h1234_5678;
    @(posedge clk);
    #1 started = 1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outputs("rst0");

    // 1: IF read, ack one cycle after mem_req, data two cycles after ack
    ack_lat = 1; rsp_lat = 2;
    clear_stats();
    if_q.push_back(32'h100);
    wait_idle("t1", 50);
    check("t1_if_rdata", if_rdata, 32'h0050_0093);
    check("t1_gnts", gnt_log.size(), 1);
    check("t1_if_rvalid_pulses", n_ifrv, 1);
    check("t1_d_rvalid_pulses", n_drv, 0);

    // 2: D write with stray mem_rvalid, then partial-strobe write and read back
    ack_lat = 1; rsp_lat = 1; stray_en = 1;
    clear_stats();
    d_q.push_back('{we: 1'b1, addr: 32'h2000, wdata: 32'hDEAD_BEEF, wstrb: 4'hF});
    wait_idle("t2", 50);
    stray_en = 0;
    check("t2_mem_written", mem[32'h2000], 32'hDEAD_BEEF);
    check("t2_gnts", gnt_log.size(), 1);
    check("t2_busy_cycles", n_busy, 2);
    check("t2_rvalid_pulses", n_ifrv + n_drv, 0);
    ack_lat = 0;
    clear_stats();
    d_q.push_back('{we: 1'b1, addr: 32'h2000, wdata: 32'h0000_CAFE, wstrb: 4'h3});
    d_q.push_back('{we: 1'b0, addr: 32'h2000, wdata: 32'h0, wstrb: 4'h0});
    wait_idle("t2b", 50);
    check("t2b_d_rdata", d_rdata, 32'hDEAD_CAFE);
    check("t2b_d_rvalid_pulses", n_drv, 1);

    // 3: contention, both requesters held for 20 transactions
    do_reset();
    check_reset_outputs("rst3");
    ack_lat = 0; rsp_lat = 1;
    clear_stats();
    for (int i = 0; i < 16; i++)
      d_q.push_back('{we: 1'b0, addr: 32'h4000 + 32'(4 * i), wdata: 32'h0, wstrb: 4'h0});
    for (int i = 0; i < 4; i++)
      if_q.push_back(32'h100 + 32'(4 * i));
    wait_idle("t3", 1000);
    check("t3_gnts", gnt_log.size(), 20);
    for (int i = 0; i < 20 && i < gnt_log.size(); i++)
      check($sformatf("t3_order_%0d", i), gnt_log[i], (i % 5 == 4) ? 0 : 1);
    check("t3_if_rvalid_pulses", n_ifrv, 4);
    check("t3_d_rvalid_pulses", n_drv, 16);
`ifdef ARB_PERF_CNT_EN
    check("t3_perf_conflict_lit", perf_conflict, 19);
`endif

    // 4: D read answered in the ack cycle
    ack_lat = 1; rsp_lat = 0;
    clear_stats();
    d_q.push_back('{we: 1'b0, addr: 32'h3000, wdata: 32'h0, wstrb: 4'h0});
    wait_idle("t4", 50);
    check("t4_d_rdata", d_rdata, 32'h1234_5678);
    check("t4_busy_cycles", n_busy, 2);
    check("t4_d_rvalid_pulses", n_drv, 1);
    check("t4_if_rvalid_pulses", n_ifrv, 0);

    // 5: reset while waiting for a response; late response must be dropped
    ack_lat = 0; rsp_lat = 3;
    clear_stats();
    if_q.push_back(32'h104);
    cyc = 0;
    while (!(m_busy && m_acked) && cyc < 20) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check("t5_reached_wait", 32'(m_busy && m_acked), 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outputs("rst5");
    repeat (6) @(posedge clk);
    #2;
    check("t5_no_rvalid_after_reset", n_ifrv + n_drv, 0);
    rsp_lat = 1;
    clear_stats();
    if_q.push_back(32'h100);
    wait_idle("t5b", 50);
    check("t5b_if_rdata", if_rdata, 32'h0050_0093);
    check("t5b_if_rvalid_pulses", n_ifrv, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation still running, required completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
